// File: rtl/iob_timer_alarm_pkg.sv
// Shared CSR map, CTRL bit positions and alarm FSM encoding for the timer alarm stage.
package iob_timer_alarm_pkg;

  localparam logic [1:0] CMP_LO = 2'd0;
  localparam logic [1:0] CMP_HI = 2'd1;
  localparam logic [1:0] PERIOD = 2'd2;
  localparam logic [1:0] CTRL   = 2'd3;

  localparam int CTRL_ARM      = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_CLR  = 2;
  localparam int CTRL_DISARM   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/iob_timer_alarm_if.sv
// Time input, CSR word-write port and alarm status outputs of the timer alarm stage.
interface iob_timer_alarm_if #(
  parameter int DATA_W = 32,
  parameter int TIME_W = 2 * DATA_W
);
  logic [TIME_W-1:0] time_i;
  logic              cfg_wen_i;
  logic [1:0]        cfg_addr_i;
  logic [DATA_W-1:0] cfg_wdata_i;
  logic              irq_o;
  logic              armed_o;
  logic              missed_o;
  logic [DATA_W-1:0] match_cnt_o;

  modport master (
    output time_i, cfg_wen_i, cfg_addr_i, cfg_wdata_i,
    input  irq_o, armed_o, missed_o, match_cnt_o
  );

  modport slave (
    input  time_i, cfg_wen_i, cfg_addr_i, cfg_wdata_i,
    output irq_o, armed_o, missed_o, match_cnt_o
  );
endinterface

// File: rtl/iob_timer_alarm_cmp.sv
// Purely combinational compare datapath: time >= cmp, next periodic compare value, overrun test.
// Zero latency; the period is zero-extended and the sum wraps modulo 2^TIME_W.
module iob_timer_alarm_cmp #(
  parameter int DATA_W = 32,
  parameter int TIME_W = 2 * DATA_W
) (
  input  logic [TIME_W-1:0] time_i,
  input  logic [TIME_W-1:0] cmp,
  input  logic [DATA_W-1:0] period,
  output logic              ge,
  output logic [TIME_W-1:0] reload,
  output logic              overrun
);

  assign ge      = (time_i >= cmp);
  assign reload  = cmp + {{(TIME_W - DATA_W){1'b0}}, period};
  assign overrun = (reload <= time_i);

endmodule

// File: rtl/iob_timer_alarm.sv
// Compare/alarm stage: matches time against a 64-bit compare value, one-shot or auto-reload.
// irq_o/match_cnt_o update on the edge closing the first matching cycle; cke_i=0 freezes everything.
module iob_timer_alarm
  import iob_timer_alarm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TIME_W = 2 * DATA_W
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  iob_timer_alarm_if.slave  bus
);

  state_t            state, state_nxt;
  logic [TIME_W-1:0] cmp_q;
  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] period_q;
  logic [DATA_W-1:0] cnt_q;
  logic              periodic_q;
  logic              irq_q;
  logic              missed_q;

  logic              wr, wr_ctrl, arm, disarm, irq_clr;
  logic              ge, overrun, fire, reload_en;
  logic [TIME_W-1:0] reload;

  assign wr      = cke_i & bus.cfg_wen_i;
  assign wr_ctrl = wr && (bus.cfg_addr_i == CTRL);
  assign arm     = wr_ctrl & bus.cfg_wdata_i[CTRL_ARM];
  assign disarm  = wr_ctrl & bus.cfg_wdata_i[CTRL_DISARM];
  assign irq_clr = wr_ctrl & bus.cfg_wdata_i[CTRL_IRQ_CLR];

  iob_timer_alarm_cmp #(.DATA_W(DATA_W), .TIME_W(TIME_W)) u_cmp (
    .time_i  (bus.time_i),
    .cmp     (cmp_q),
    .period  (period_q),
    .ge      (ge),
    .reload  (reload),
    .overrun (overrun)
  );

  // A disarm in the matching cycle suppresses the fire entirely.
  assign fire      = cke_i && (state == ARMED) && ge && !disarm;
  assign reload_en = fire && periodic_q && (period_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else if (cke_i) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm && !disarm) state_nxt = ARMED;
      ARMED: begin
        if (disarm)    state_nxt = IDLE;
        else if (fire) state_nxt = reload_en ? ARMED : HOLD;
      end
      HOLD: begin
        if (disarm)   state_nxt = IDLE;
        else if (arm) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.armed_o = (state == ARMED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q      <= '0;
      shadow_q   <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      missed_q   <= 1'b0;
    end else if (cke_i) begin
      if (wr && bus.cfg_addr_i == CMP_LO) shadow_q <= bus.cfg_wdata_i;
      if (wr && bus.cfg_addr_i == PERIOD) period_q <= bus.cfg_wdata_i;

      // The high-word write commits both halves so the compare never sees a torn value.
      if (wr && bus.cfg_addr_i == CMP_HI) cmp_q <= {bus.cfg_wdata_i, shadow_q};
      else if (reload_en)                 cmp_q <= reload;

      if (arm && !disarm) periodic_q <= bus.cfg_wdata_i[CTRL_PERIODIC];

      if (fire)         irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;

      if (irq_clr)                    missed_q <= reload_en & overrun;
      else if (reload_en && overrun)  missed_q <= 1'b1;

      if (fire) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.irq_o       = irq_q;
  assign bus.missed_o    = missed_q;
  assign bus.match_cnt_o = cnt_q;

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Directed bench for iob_timer_alarm: counter-driven sequences plus a per-cycle vector table.
module tb_iob_timer_alarm;
  import iob_timer_alarm_pkg::*;

  typedef struct {
    logic        rst;
    logic        cke;
    logic        wen;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [63:0] tm;
    logic        irq;
    logic        armed;
    logic        missed;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic cke;
  logic rst;
  logic run;
  int   n_assert = 0;
  int   n_fail   = 0;

  iob_timer_alarm_if #(.DATA_W(32), .TIME_W(64)) bus ();

  iob_timer_alarm #(.DATA_W(32), .TIME_W(64)) dut (
    .clk_i (clk),
    .cke_i (cke),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic irq, input logic armed,
                            input logic missed, input logic [31:0] cnt);
    check({tag, " irq"},    {63'd0, bus.irq_o},    {63'd0, irq});
    check({tag, " armed"},  {63'd0, bus.armed_o},  {63'd0, armed});
    check({tag, " missed"}, {63'd0, bus.missed_o}, {63'd0, missed});
    check({tag, " cnt"},    {32'd0, bus.match_cnt_o}, {32'd0, cnt});
  endtask

  // Inputs change and outputs are sampled on the falling edge; time advances once per cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (run) bus.time_i = bus.time_i + 64'd1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_wen_i   = 1'b1;
    bus.cfg_addr_i  = a;
    bus.cfg_wdata_i = d;
    tick();
    bus.cfg_wen_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic w, input logic [1:0] a,
                              input logic [31:0] d, input logic [63:0] t, input logic ei,
                              input logic ea, input logic em, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.cke = c; v.wen = w; v.addr = a; v.wdata = d; v.tm = t;
    v.irq = ei; v.armed = ea; v.missed = em; v.cnt = ec;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    int          fires[$];
    logic [31:0] prev;

    // Collision/cke/reset vectors: inputs held for one cycle, outputs expected after that edge.
    tbl.push_back(mk(1, 1, 0, CMP_LO,  0,  5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, CMP_LO, 20, 10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, CMP_HI,  0, 11, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, CTRL,    1, 12, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, CMP_LO,  0, 19, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, CTRL,    4, 20, 1, 0, 0, 1));  // irq_clear on fire: fire wins
    tbl.push_back(mk(0, 1, 1, CTRL,    4, 21, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, CTRL,    1, 22, 0, 1, 0, 1));  // HOLD -> ARMED
    tbl.push_back(mk(0, 1, 1, CTRL,    8, 23, 0, 0, 0, 1));  // disarm on fire: disarm wins
    tbl.push_back(mk(0, 1, 1, CTRL,    9, 24, 0, 0, 0, 1));  // arm+disarm: stays IDLE
    tbl.push_back(mk(0, 1, 1, CMP_LO, 40, 25, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, CMP_HI,  0, 26, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, CTRL,    1, 27, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, CMP_LO,  0, 39, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, CMP_LO,  0, 40, 0, 1, 0, 1));  // match while frozen
    tbl.push_back(mk(0, 0, 1, CTRL,    8, 41, 0, 1, 0, 1));  // dropped write
    tbl.push_back(mk(0, 1, 0, CMP_LO,  0, 42, 1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, CMP_LO,  0, 43, 0, 0, 0, 0));  // reset beats cke=0
    tbl.push_back(mk(0, 1, 1, CTRL,    1, 44, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, CMP_LO,  0, 45, 1, 0, 0, 1));  // cmp back to 0 after reset

    cke = 1'b1;
    rst = 1'b1;
    run = 1'b1;
    bus.time_i      = '0;
    bus.cfg_wen_i   = 1'b0;
    bus.cfg_addr_i  = '0;
    bus.cfg_wdata_i = '0;

    // Reset held three cycles with time running, then no fire from IDLE with cmp=0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("reset%0d", i), 0, 0, 0, 0);
    end
    rst = 1'b0;
    repeat (5) tick();
    check_outs("post_reset", 0, 0, 0, 0);

    // One-shot at 100, armed at time 10.
    do_reset();
    bus.time_i = 64'd8;
    cfg_write(CMP_LO, 32'd100);
    cfg_write(CMP_HI, 32'd0);
    cfg_write(CTRL, 32'd1);
    for (int i = 0; i < 300 && !bus.irq_o; i++) tick();
    check("oneshot irq_time", bus.time_i, 64'd101);
    check_outs("oneshot", 1, 0, 0, 1);
    cfg_write(CTRL, 32'd4);
    check_outs("oneshot_clr", 0, 0, 0, 1);
    repeat (5) tick();
    check_outs("oneshot_stay", 0, 0, 0, 1);

    // Periodic: 50 + k*20.
    do_reset();
    bus.time_i = 64'd0;
    cfg_write(CMP_LO, 32'd50);
    cfg_write(CMP_HI, 32'd0);
    cfg_write(PERIOD, 32'd20);
    cfg_write(CTRL, 32'd3);
    prev = bus.match_cnt_o;
    while (bus.time_i < 64'd91) begin
      tick();
      if (bus.match_cnt_o != prev) fires.push_back(int'(bus.time_i) - 1);
      prev = bus.match_cnt_o;
    end
    check("periodic nfires", 64'(fires.size()), 64'd3);
    check("periodic fire0", 64'(fires.size() > 0 ? fires[0] : -1), 64'd50);
    check("periodic fire1", 64'(fires.size() > 1 ? fires[1] : -1), 64'd70);
    check("periodic fire2", 64'(fires.size() > 2 ? fires[2] : -1), 64'd90);
    check_outs("periodic", 1, 1, 0, 3);

    // Atomic 64-bit commit across the 32-bit boundary.
    do_reset();
    bus.time_i = 64'h0_FFFF_FFF0;
    cfg_write(CMP_LO, 32'hFFFF_FFFF);
    cfg_write(CMP_HI, 32'hFFFF_FFFF);
    cfg_write(CMP_LO, 32'h10);
    cfg_write(CTRL, 32'd1);
    repeat (3) tick();
    check_outs("atomic_lo_only", 0, 1, 0, 0);
    cfg_write(CMP_HI, 32'd1);
    for (int i = 0; i < 100 && !bus.irq_o; i++) tick();
    check("atomic irq_time", bus.time_i, 64'h1_0000_0011);
    check_outs("atomic", 1, 0, 0, 1);

    // Overrun: cmp=5 far behind time=200, period 10 catches up after 22 back-to-back fires.
    do_reset();
    bus.time_i = 64'd196;
    cfg_write(CMP_LO, 32'd5);
    cfg_write(CMP_HI, 32'd0);
    cfg_write(PERIOD, 32'd10);
    cfg_write(CTRL, 32'd3);
    check_outs("overrun_armed", 0, 1, 0, 0);
    tick();
    check_outs("overrun_first", 1, 1, 1, 1);
    for (int i = 0; i < 100 && bus.time_i < 64'd223; i++) tick();
    check_outs("overrun_chain", 1, 1, 1, 22);
    cfg_write(CTRL, 32'd4);
    check_outs("overrun_clr", 0, 1, 0, 22);
    tick();
    check_outs("overrun_gap", 0, 1, 0, 22);
    tick();
    check_outs("overrun_next", 1, 1, 0, 23);

    run = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      rst             = tbl[i].rst;
      cke             = tbl[i].cke;
      bus.cfg_wen_i   = tbl[i].wen;
      bus.cfg_addr_i  = tbl[i].addr;
      bus.cfg_wdata_i = tbl[i].wdata;
      bus.time_i      = tbl[i].tm;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].irq, tbl[i].armed, tbl[i].missed, tbl[i].cnt);
    end
    rst           = 1'b0;
    cke           = 1'b1;
    bus.cfg_wen_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
